// File: rtl/mem_if_pkg.sv
// Shared types and default window map for the region-decoding memory interface.
package mem_if_pkg;

  localparam int unsigned MEM_IF_MAX_REGIONS = 8;
  localparam int unsigned REGION_IDX_W       = $clog2(MEM_IF_MAX_REGIONS);

  localparam logic [31:0] MEM_IF_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] MEM_IF_TEXT_END  = 32'h0040_FFFF;
  localparam logic [31:0] MEM_IF_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] MEM_IF_DATA_END  = 32'h1001_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } mem_if_state_t;

endpackage

// File: rtl/mem_region_decoder.sv
// Combinational window decode: hit vector, lowest-index priority select and
// region-relative word address.
module mem_region_decoder
  import mem_if_pkg::*;
#(
  parameter int unsigned NUM_REGIONS  = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 16,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {MEM_IF_TEXT_BASE, MEM_IF_DATA_BASE},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_END  = {MEM_IF_TEXT_END, MEM_IF_DATA_END}
) (
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  output logic                    hit_o,
  output logic [REGION_IDX_W-1:0] region_o,
  output logic [OFFSET_WIDTH-3:0] word_o
);

  logic [NUM_REGIONS-1:0] hits;
  logic [ADDR_WIDTH-1:0]  sel_base;

  // Window lists are written MSB-first, so region 0 sits in the top slice.
  function automatic logic [ADDR_WIDTH-1:0] window(
    input logic [NUM_REGIONS*ADDR_WIDTH-1:0] v,
    input int unsigned                       i
  );
    return v[(NUM_REGIONS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      hits[i] = (addr_i >= window(REGION_BASE, i)) && (addr_i <= window(REGION_END, i));
    end
  end

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit_o    = |hits;
    region_o = '0;
    sel_base = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        region_o = REGION_IDX_W'(i);
        sel_base = window(REGION_BASE, i);
      end
    end
  end

  assign word_o = (OFFSET_WIDTH-2)'((addr_i - sel_base) >> 2);

endmodule

// File: rtl/mem_region_interface.sv
// Multi-region load/store bridge to synchronous RAMs with read-latency wait and
// unmapped-access reporting. Define MEM_IF_BUS_ERROR_EN to drive wBusError.
module mem_region_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned NUM_REGIONS  = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {MEM_IF_TEXT_BASE, MEM_IF_DATA_BASE},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_END  = {MEM_IF_TEXT_END, MEM_IF_DATA_END}
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              wReadEnable,
  input  logic                              wWriteEnable,
  input  logic [DATA_WIDTH/8-1:0]           wByteEnable,
  input  logic [ADDR_WIDTH-1:0]             wAddress,
  input  logic [DATA_WIDTH-1:0]             wWriteData,
  output logic [DATA_WIDTH-1:0]             wReadData,
  output logic                              wReady,
  output logic                              wBusError,
  output logic [OFFSET_WIDTH-3:0]           oMemAddress,
  output logic [DATA_WIDTH/8-1:0]           oMemByteEnable,
  output logic [DATA_WIDTH-1:0]             oMemWriteData,
  output logic [NUM_REGIONS-1:0]            oMemRead,
  output logic [NUM_REGIONS-1:0]            oMemWrite,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] iMemReadData
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  mem_if_state_t             state_q, state_d;
  logic [REGION_IDX_W-1:0]   region_q, region_d;
  logic                      write_q, write_d;
  logic [OFFSET_WIDTH-3:0]   addr_q, addr_d;
  logic [BeW-1:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      req;
  logic                      dec_hit;
  logic [REGION_IDX_W-1:0]   dec_region;
  logic [OFFSET_WIDTH-3:0]   dec_word;
  logic [DATA_WIDTH-1:0]     rd_slice;
  logic [NUM_REGIONS-1:0]    strobe;

  assign req = wReadEnable | wWriteEnable;

  mem_region_decoder #(
    .NUM_REGIONS  (NUM_REGIONS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .REGION_BASE  (REGION_BASE),
    .REGION_END   (REGION_END)
  ) u_decoder (
    .addr_i   (wAddress),
    .hit_o    (dec_hit),
    .region_o (dec_region),
    .word_o   (dec_word)
  );

  always_comb begin
    rd_slice = '0;
    strobe   = '0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (region_q == REGION_IDX_W'(r)) begin
        rd_slice  = iMemReadData[r*DATA_WIDTH +: DATA_WIDTH];
        strobe[r] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    write_d  = write_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          region_d = dec_region;
          write_d  = wWriteEnable;
          addr_d   = dec_word;
          be_d     = wByteEnable;
          wdata_d  = wWriteData;
          if (dec_hit) begin
            state_d = StAccess;
          end else begin
            state_d = StResp;
            // Unmapped loads return zero; unmapped stores leave the load data alone.
            if (!wWriteEnable) rdata_d = '0;
          end
        end
      end
      StAccess: begin
        cnt_d   = '0;
        state_d = write_q ? StResp : StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(READ_LATENCY - 1)) begin
          rdata_d = rd_slice;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= StIdle;
      region_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    oMemRead  = '0;
    oMemWrite = '0;
    if (state_q == StAccess) begin
      if (write_q) oMemWrite = strobe;
      else         oMemRead  = strobe;
    end
  end

  assign wReady         = (state_q == StResp);
  assign wReadData      = rdata_q;
  assign oMemAddress    = addr_q;
  assign oMemByteEnable = be_q;
  assign oMemWriteData  = wdata_q;

`ifdef MEM_IF_BUS_ERROR_EN
  logic err_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && req) begin
      err_q <= ~dec_hit;
    end
  end

  assign wBusError = err_q & (state_q == StResp);
`else
  assign wBusError = 1'b0;
`endif

endmodule
